// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI-to-register-bus bridge: command codes, FSM states, read latency.
package spi_reg_pkg;

  localparam logic [7:0] CMD_WR   = 8'h80;
  localparam logic [7:0] CMD_RD   = 8'h00;
  localparam int         READ_LAT = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DROP = 3'd4
  } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses derived
// from the last two synchronized samples.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 3-byte host frames into register-bus writes/reads.
// Define SPI_REG_BRIDGE_BURST_EN to continue past the data byte at incrementing addresses.
module spi_reg_bridge #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk_10,
  input  logic                  i_rst,
  input  logic                  i_spi_sclk,
  input  logic                  i_spi_cs_n,
  input  logic                  i_spi_mosi,
  output logic                  o_spi_miso,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_frame_err
);
  import spi_reg_pkg::*;

  state_t                r_state, w_state_nxt;
  logic                  w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic                  w_cs_n, w_cs_rise, w_cs_fall;
  logic                  w_mosi, w_mosi_rise, w_mosi_fall;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_rx, r_tx;
  logic                  r_is_rd, r_wr_pend, r_wr, r_miso, r_frame_err;
  logic [1:0]            r_rd_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_in_frame, w_bit, w_byte_done, w_cmd_ok, w_tx_shift;
  logic [7:0]            w_byte;
  logic                  w_unused;
`ifdef SPI_REG_BRIDGE_BURST_EN
  logic                  r_burst;
`endif

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .i_clk(i_clk_10), .i_rst(i_rst), .i_d(i_spi_sclk),
    .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .i_clk(i_clk_10), .i_rst(i_rst), .i_d(i_spi_cs_n),
    .o_q(w_cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .i_clk(i_clk_10), .i_rst(i_rst), .i_d(i_spi_mosi),
    .o_q(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

  assign w_unused = &{1'b0, w_sclk_q, w_mosi_rise, w_mosi_fall};

  // A CS_N rise already shows w_cs_n high, so a coincident SCLK rise is discarded.
  assign w_in_frame  = (r_state == CMD) || (r_state == ADDR) || (r_state == DATA);
  assign w_bit       = w_in_frame & ~w_cs_n & w_sclk_rise;
  assign w_byte      = {r_rx[6:0], w_mosi};
  assign w_byte_done = w_bit & (r_bit_cnt == 3'd7);
  assign w_cmd_ok    = (w_byte == CMD_WR) || (w_byte == CMD_RD);
  assign w_tx_shift  = w_sclk_fall & r_is_rd & (w_state_nxt == DATA);

  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_cs_fall) w_state_nxt = CMD;
        CMD:     if (w_byte_done) w_state_nxt = w_cmd_ok ? ADDR : DROP;
        ADDR:    if (w_byte_done) w_state_nxt = DATA;
`ifdef SPI_REG_BRIDGE_BURST_EN
        DATA:    if (w_byte_done) w_state_nxt = DATA;
`else
        DATA:    if (w_byte_done) w_state_nxt = CMD;
`endif
        DROP:    w_state_nxt = DROP;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_10 or posedge i_rst) begin
    if (i_rst) begin
      r_bit_cnt   <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_is_rd     <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_wr        <= 1'b0;
      r_miso      <= 1'b0;
      r_frame_err <= 1'b0;
      r_rd_cnt    <= '0;
      r_addr      <= '0;
      r_data      <= '0;
`ifdef SPI_REG_BRIDGE_BURST_EN
      r_burst     <= 1'b0;
`endif
    end else begin
      r_wr      <= r_wr_pend;
      r_wr_pend <= 1'b0;
      if (r_rd_cnt != 2'd0) r_rd_cnt <= r_rd_cnt - 2'd1;

      if (w_cs_rise) begin
        r_bit_cnt <= '0;
        if (w_in_frame && (r_bit_cnt != 3'd0)) r_frame_err <= 1'b1;
      end else if (w_bit) begin
        r_rx      <= w_byte;
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (w_byte_done) begin
          case (r_state)
            CMD: begin
              if (w_cmd_ok) begin
                r_is_rd     <= (w_byte == CMD_RD);
                r_frame_err <= 1'b0;
              end else begin
                r_frame_err <= 1'b1;
              end
            end
            ADDR: begin
              r_addr <= ADDR_WIDTH'(w_byte);
              if (r_is_rd) r_rd_cnt <= 2'(READ_LAT);
`ifdef SPI_REG_BRIDGE_BURST_EN
              r_burst <= 1'b0;
`endif
            end
            DATA: begin
`ifdef SPI_REG_BRIDGE_BURST_EN
              // Reads prefetch the next address; writes after the first byte target addr+1.
              if (r_is_rd) begin
                r_addr   <= r_addr + ADDR_WIDTH'(1);
                r_rd_cnt <= 2'(READ_LAT);
              end else if (r_burst) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
              end
              r_burst <= 1'b1;
`endif
              if (!r_is_rd) begin
                r_data    <= DATA_WIDTH'(w_byte);
                r_wr_pend <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      if (r_rd_cnt == 2'd1) r_tx <= 8'(i_data);
      else if (w_tx_shift)  r_tx <= {r_tx[6:0], 1'b0};

      if ((w_state_nxt != DATA) || !r_is_rd) r_miso <= 1'b0;
      else if (w_tx_shift)                    r_miso <= r_tx[7];
    end
  end

  assign o_spi_miso  = r_miso;
  assign o_addr      = r_addr;
  assign o_data      = r_data;
  assign o_wr        = r_wr;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: 1 MHz mode-0 host against a 10 MHz core clock.
`timescale 1ns/1ps
module tb_spi_reg_bridge;
  import spi_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi;
  logic       miso, wr, ferr;
  logic [7:0] addr, wdata, rdata;
  logic [7:0] addr_d;

  int         n_chk = 0;
  int         n_err = 0;
  int         wr_cnt = 0;
  int         wr_base;
  logic [7:0] wa [0:63];
  logic [7:0] wd [0:63];
  logic [7:0] rx, rx2, rx3;

  always #50 clk = ~clk;

  spi_reg_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_clk_10(clk), .i_rst(rst), .i_spi_sclk(sclk), .i_spi_cs_n(cs_n),
    .i_spi_mosi(mosi), .o_spi_miso(miso), .o_addr(addr), .o_data(wdata),
    .o_wr(wr), .i_data(rdata), .o_frame_err(ferr));

  function automatic logic [7:0] reg_model(input logic [7:0] a);
    return (a == 8'h34) ? 8'h5C : (a ^ 8'hFF);
  endfunction

  // Read-back model: settles about 1.5 cycles after o_addr changes.
  always @(negedge clk) begin
    rdata  = reg_model(addr_d);
    addr_d = addr;
  end

  always @(negedge clk) begin
    if (wr === 1'b1) begin
      wa[wr_cnt & 63] = addr;
      wd[wr_cnt & 63] = wdata;
      wr_cnt++;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rxb);
    rxb = '0;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      #500 sclk = 1'b1;
      rxb[i] = miso;
      #500 sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           output logic [7:0] rxd);
    logic [7:0] junk;
    cs_n = 1'b0;
    #500;
    spi_bits(b0, 8, junk);
    spi_bits(b1, 8, junk);
    spi_bits(b2, 8, rxd);
    #500 cs_n = 1'b1;
    #2000;
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; addr_d = '0; rdata = '0;
    #30;
    chk_eq("rst_addr", 32'(addr), 32'h0);
    chk_eq("rst_data", 32'(wdata), 32'h0);
    chk_eq("rst_wr", 32'(wr), 32'h0);
    chk_eq("rst_miso", 32'(miso), 32'h0);
    chk_eq("rst_ferr", 32'(ferr), 32'h0);
    chk_eq("rst_state", 32'(dut.r_state), 32'(IDLE));
    #200 rst = 1'b0;
    #1000;

    // Plain write
    wr_base = wr_cnt;
    spi_frame(8'h80, 8'h12, 8'hA5, rx);
    chk_eq("wr_count", 32'(wr_cnt - wr_base), 32'd1);
    chk_eq("wr_addr", 32'(wa[wr_base & 63]), 32'h12);
    chk_eq("wr_data", 32'(wd[wr_base & 63]), 32'hA5);
    chk_eq("wr_ferr", 32'(ferr), 32'h0);

    // Read of 0x34
    wr_base = wr_cnt;
    spi_frame(8'h00, 8'h34, 8'h00, rx);
    chk_eq("rd_miso", 32'(rx), 32'h5C);
    chk_eq("rd_no_wr", 32'(wr_cnt - wr_base), 32'd0);
    chk_eq("rd_addr", 32'(addr), 32'h34);
    chk_eq("rd_data_held", 32'(wdata), 32'hA5);
    chk_eq("rd_miso_idle", 32'(miso), 32'h0);

    // Write aborted after 4 data bits
    wr_base = wr_cnt;
    cs_n = 1'b0;
    #500;
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h20, 8, rx);
    spi_bits(8'hC3, 4, rx);
    #500 cs_n = 1'b1;
    #2000;
    chk_eq("abort_no_wr", 32'(wr_cnt - wr_base), 32'd0);
    chk_eq("abort_ferr", 32'(ferr), 32'h1);
    chk_eq("abort_state", 32'(dut.r_state), 32'(IDLE));
    chk_eq("abort_data_held", 32'(wdata), 32'hA5);
    wr_base = wr_cnt;
    spi_frame(8'h80, 8'h21, 8'h3C, rx);
    chk_eq("recover_ferr", 32'(ferr), 32'h0);
    chk_eq("recover_count", 32'(wr_cnt - wr_base), 32'd1);
    chk_eq("recover_addr", 32'(wa[wr_base & 63]), 32'h21);
    chk_eq("recover_data", 32'(wd[wr_base & 63]), 32'h3C);

    // Bad command 0x41
    wr_base = wr_cnt;
    cs_n = 1'b0;
    #500;
    spi_bits(8'h41, 8, rx);
    chk_eq("bad_state", 32'(dut.r_state), 32'(DROP));
    chk_eq("bad_ferr", 32'(ferr), 32'h1);
    spi_bits(8'h55, 8, rx2);
    spi_bits(8'hAA, 8, rx3);
    chk_eq("bad_miso", 32'(rx2 | rx3), 32'h0);
    chk_eq("bad_no_wr", 32'(wr_cnt - wr_base), 32'd0);
    chk_eq("bad_addr_held", 32'(addr), 32'h21);
    #500 cs_n = 1'b1;
    #2000;
    chk_eq("bad_ferr_sticky", 32'(ferr), 32'h1);

    // Reset during the address byte
    wr_base = wr_cnt;
    cs_n = 1'b0;
    #500;
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h66, 4, rx);
    rst = 1'b1;
    #1;
    chk_eq("mid_rst_addr", 32'(addr), 32'h0);
    chk_eq("mid_rst_data", 32'(wdata), 32'h0);
    chk_eq("mid_rst_ferr", 32'(ferr), 32'h0);
    chk_eq("mid_rst_wr", 32'(wr), 32'h0);
    chk_eq("mid_rst_state", 32'(dut.r_state), 32'(IDLE));
    #199 rst = 1'b0;
    spi_bits(8'h06, 4, rx);
    spi_bits(8'h99, 8, rx);
    #500 cs_n = 1'b1;
    #2000;
    chk_eq("mid_rst_no_wr", 32'(wr_cnt - wr_base), 32'd0);
    wr_base = wr_cnt;
    spi_frame(8'h80, 8'h05, 8'h01, rx);
    chk_eq("post_rst_count", 32'(wr_cnt - wr_base), 32'd1);
    chk_eq("post_rst_addr", 32'(wa[wr_base & 63]), 32'h05);
    chk_eq("post_rst_data", 32'(wd[wr_base & 63]), 32'h01);
    chk_eq("post_rst_ferr", 32'(ferr), 32'h0);

`ifdef SPI_REG_BRIDGE_BURST_EN
    wr_base = wr_cnt;
    cs_n = 1'b0;
    #500;
    spi_bits(8'h80, 8, rx);
    spi_bits(8'hFE, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    spi_bits(8'h33, 8, rx);
    #500 cs_n = 1'b1;
    #2000;
    chk_eq("burst_count", 32'(wr_cnt - wr_base), 32'd3);
    chk_eq("burst_a0", 32'(wa[wr_base & 63]), 32'hFE);
    chk_eq("burst_d0", 32'(wd[wr_base & 63]), 32'h11);
    chk_eq("burst_a1", 32'(wa[(wr_base + 1) & 63]), 32'hFF);
    chk_eq("burst_d1", 32'(wd[(wr_base + 1) & 63]), 32'h22);
    chk_eq("burst_a2", 32'(wa[(wr_base + 2) & 63]), 32'h00);
    chk_eq("burst_d2", 32'(wd[(wr_base + 2) & 63]), 32'h33);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- SPI slave front-end that acts as the initiator on the on-chip register bus.
- Drives the address/data/write-strobe bus shared by the pps_div_block instances and other register blocks.
- Returns their read-back data to the host controller.
- Turns serial host frames into single-cycle register writes and register reads, all in the 10 MHz domain.

Parameters:
- ADDR_WIDTH, 8, register bus address width; must equal `ADDR_WIDTH from address_map.vh.
- DATA_WIDTH, 8, register bus data width; must equal `DATA_WIDTH.
- SYNC_STAGES, 2, flip-flop stages on the SCLK, CS_N and MOSI synchronizers (minimum 2).

Ports:
- i_clk_10  in  1  10 MHz system clock; the only clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_spi_sclk  in  1  host SPI clock, mode 0 (CPOL=0, CPHA=0), at most 1 MHz.
- i_spi_cs_n  in  1  host chip select, active low; frames the transaction.
- i_spi_mosi  in  1  host data in, MSB first.
- o_spi_miso  out  1  read data to host, MSB first. Driven 0 when not in a read data phase.
- o_addr  out  ADDR_WIDTH  register bus address.
- o_data  out  DATA_WIDTH  register bus write data.
- o_wr  out  1  one-cycle write strobe.
- i_data  in  DATA_WIDTH  OR-combined read-back data from the register blocks; valid 2 cycles after o_addr changes.
- o_frame_err  out  1  sticky flag: a frame was aborted mid-byte or carried a bad command. Cleared by reset or by a valid command byte.

Behaviour:
- Reset values: o_addr=0, o_data=0, o_wr=0, o_spi_miso=0, o_frame_err=0, FSM=IDLE, bit counter=0.
- Inputs pass through SYNC_STAGES flip-flops. SCLK rise/fall are detected from the last two synchronized samples.
- All actions below are timed from the detected edge, not from the raw pin.
- Frame format: 3 bytes, MSB first.
  - Byte 0 is the command: 0x80 = write, 0x00 = read. Any other value is a bad command.
  - Byte 1 is the address.
  - Byte 2 is data: MOSI carries it for a write; MISO returns it for a read.
- MOSI is sampled on SCLK rising edges. MISO changes on SCLK falling edges.
- FSM states: IDLE, CMD, ADDR, DATA, DROP.
  - IDLE -> CMD on CS_N falling.
  - CMD -> ADDR after 8 bits with a valid command. A bad command sets o_frame_err and goes to DROP.
  - ADDR -> DATA after 8 bits. o_addr is updated in the cycle after the 8th rising edge.
  - For a read, i_data is captured exactly 2 cycles after o_addr updates and loaded into the transmit shift register. Its MSB is driven on the next SCLK falling edge. The remaining bits shift out on the following 7 falling edges.
  - DATA (write): after the 8th rising edge, o_data takes the received byte. o_wr pulses high for exactly 1 cycle, in the cycle after o_data updates. The FSM then returns to CMD for the next command.
  - DATA (read): after 8 bits, returns to CMD.
  - DROP: ignores SCLK until CS_N rises.
- CS_N rising in any state forces IDLE within 1 cycle of the synchronized edge.
  - If a byte is partially received (bit count 1-7), o_frame_err is set.
  - No o_wr is ever issued for an incomplete data byte.
- CS_N high: SCLK edges are ignored and the bit counter is held at 0.
- SCLK rise and CS_N rise detected in the same cycle: CS_N wins and the bit is discarded.
- o_addr and o_data hold their last values between transactions. They are never cleared except by reset.
- Asynchronous reset mid-frame: immediate return to reset values. No write is issued. The host must restart the frame.
- Bit counter is 3 bits and wraps 7 -> 0 at each byte boundary.

Optional Feature:
- Macro: SPI_REG_BRIDGE_BURST_EN.
- Defined: after the DATA byte, further bytes while CS_N stays low continue the same operation at o_addr+1 (modulo 2^ADDR_WIDTH; 0xFF wraps to 0x00).
  - Burst write issues one o_wr per byte.
  - Burst read prefetches the next address so it meets the same MISO timing.
- Not defined: after the DATA byte, the FSM expects a new command byte (described above).

Decomposition:
- Shared package (spi_reg_pkg.vh):
  - command codes CMD_WR=8'h80, CMD_RD=8'h00;
  - FSM state encodings;
  - READ_LAT=2.
- Sub-module: spi_edge_sync. One instance per input; contains the SYNC_STAGES synchronizer plus rise/fall detect outputs.

Test Plan:
- Write frame 0x80,0x12,0xA5 at 1 MHz -> exactly one o_wr pulse with o_addr=0x12, o_data=0xA5; o_frame_err stays 0.
- Read frame 0x00,0x34 with the register model returning 0x5C at addr 0x34 -> MISO shifts 0x5C during byte 2; no o_wr.
- CS_N raised after 4 bits of the data byte in a write to 0x20 -> no o_wr, o_frame_err=1, FSM in IDLE; the next valid frame clears the flag.
- Bad command 0x41 -> o_frame_err=1, remaining bytes ignored, no bus activity until CS_N rises.
- Assert i_rst during the address byte -> all outputs 0 immediately; a subsequent full write to 0x05 with data 0x01 succeeds.
- With SPI_REG_BRIDGE_BURST_EN: write 0x80,0xFE,0x11,0x22,0x33 -> three o_wr pulses at addresses 0xFE, 0xFF, 0x00 with data 0x11, 0x22, 0x33.
